// File: rtl/mem_arbiter_if.sv
// Loader-side port of the memory arbiter: request/grant handshake plus the beat bus.
// The ldr_timeout strobe exists only when ARB_TIMEOUT_EN is defined.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              ldr_req;
  logic              ldr_valid;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic [DATA_W-1:0] ldr_rdata;
`ifdef ARB_TIMEOUT_EN
  logic              ldr_timeout;

  modport master (
    output ldr_req, ldr_valid, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rdata, ldr_timeout
  );
  modport slave (
    input  ldr_req, ldr_valid, ldr_we, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rdata, ldr_timeout
  );
`else
  modport master (
    output ldr_req, ldr_valid, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rdata
  );
  modport slave (
    input  ldr_req, ldr_valid, ldr_we, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rdata
  );
`endif
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory between the CPU (default owner) and a loader granted at instruction
// boundaries for bounded bursts. Optional idle-grant revocation: define ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_boundary,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic              cpu_hold,
  mem_arbiter_if.slave      ldr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MAX_BURST < 1 || MAX_BURST > 255 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("mem_arbiter: MAX_BURST and TIMEOUT must lie in 1..255");
  end

  localparam logic [1:0] S_CPU  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_LDR  = 2'd2;
  localparam logic [1:0] S_COOL = 2'd3;

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] beat_cnt;
  logic       granted;
  logic       beat;
  logic       burst_done;
  logic       timeout_hit;
  logic       release_ldr;
  logic       enter_ldr;

  assign granted    = (state == S_LDR);
  assign beat       = granted & ldr.ldr_valid;
  assign burst_done = beat && ((beat_cnt + 8'd1) == BURST_LIM);
  assign enter_ldr  = (state == S_WAIT) && cpu_boundary && ldr.ldr_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] IDLE_LIM = 8'(TIMEOUT - 1);

  logic [7:0] idle_cnt;
  logic       timeout_q;

  assign timeout_hit = granted && !ldr.ldr_valid && (idle_cnt == IDLE_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (enter_ldr || beat)
        idle_cnt <= 8'd0;
      else if (granted)
        idle_cnt <= idle_cnt + 8'd1;
    end
  end

  assign ldr.ldr_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  assign release_ldr = !ldr.ldr_req || burst_done || timeout_hit;

  // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CPU:  if (ldr.ldr_req) state_nxt = S_WAIT;
      S_WAIT: begin
        if (cpu_boundary && ldr.ldr_req) state_nxt = S_LDR;
        else if (!ldr.ldr_req)           state_nxt = S_CPU;
      end
      S_LDR:  if (release_ldr) state_nxt = S_COOL;
      S_COOL: if (cpu_boundary) state_nxt = ldr.ldr_req ? S_WAIT : S_CPU;
      default: state_nxt = S_CPU;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_CPU;
      beat_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (enter_ldr)
        beat_cnt <= 8'd0;
      else if (beat)
        beat_cnt <= beat_cnt + 8'd1;
    end
  end

  // Grant and hold decode straight from the state register, so they drop with async reset.
  assign ldr.ldr_gnt   = granted;
  assign cpu_hold      = granted;
  assign ldr.ldr_rdata = mem_rdata;

  always_comb begin
    if (granted) begin
      mem_addr  = ldr.ldr_addr;
      mem_wdata = ldr.ldr_wdata;
      mem_we    = ldr.ldr_we & ldr.ldr_valid;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MAX_BURST=4, TIMEOUT=8) with a 256-byte memory model.
// The idle-timeout section runs only when ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_boundary;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_hold;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [0:255];

  int n_chk = 0;
  int n_err = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_boundary(cpu_boundary), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_hold(cpu_hold),
    .ldr(bus.slave),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic we, input logic [15:0] a, input logic [7:0] d);
    bus.ldr_valid = 1'b1;
    bus.ldr_we    = we;
    bus.ldr_addr  = a;
    bus.ldr_wdata = d;
  endtask

  initial begin
    rst = 1'b0;
    cpu_boundary = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    bus.ldr_req = 1'b0; bus.ldr_valid = 1'b0; bus.ldr_we = 1'b0;
    bus.ldr_addr = '0; bus.ldr_wdata = '0;

    // Reset: CPU path selected, no grant.
    #3;
    cpu_we = 1'b1;
    #1;
    check("rst_gnt", bus.ldr_gnt, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_mem_we", mem_we, 1);
`ifdef ARB_TIMEOUT_EN
    check("rst_timeout", bus.ldr_timeout, 0);
`endif
    cpu_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1. CPU write 0x5A @ 0x0010.
    cpu_addr = 16'h0010; cpu_wdata = 8'h5A; cpu_we = 1'b1;
    #1;
    check("cpu_mem_addr", mem_addr, 16'h0010);
    check("cpu_mem_wdata", mem_wdata, 8'h5A);
    check("cpu_mem_we", mem_we, 1);
    tick();
    cpu_we = 1'b0;
    #1;
    check("cpu_readback", bus.ldr_rdata, 8'h5A);
    check("idle_gnt", bus.ldr_gnt, 0);
    check("idle_hold", cpu_hold, 0);

    // Loader beats without a grant are ignored.
    beat(1'b1, 16'h0030, 8'hEE);
    #1;
    check("nognt_we", mem_we, 0);
    check("nognt_addr", mem_addr, 16'h0010);
    tick();
    bus.ldr_valid = 1'b0; bus.ldr_we = 1'b0;

    // 2. Request mid-instruction, boundary three cycles later.
    bus.ldr_req = 1'b1;
    tick();
    check("wait_gnt0", bus.ldr_gnt, 0);
    tick();
    tick();
    cpu_boundary = 1'b1;
    #1;
    check("pre_edge_gnt", bus.ldr_gnt, 0);
    tick();
    cpu_boundary = 1'b0;
    check("grant_gnt", bus.ldr_gnt, 1);
    check("grant_hold", cpu_hold, 1);

    // Beat 1: write 0xA5 @ 0x0020 while the CPU tries to write elsewhere.
    beat(1'b1, 16'h0020, 8'hA5);
    cpu_addr = 16'h0010; cpu_wdata = 8'hFF; cpu_we = 1'b1;
    #1;
    check("ldr_mem_addr", mem_addr, 16'h0020);
    check("ldr_mem_wdata", mem_wdata, 8'hA5);
    check("ldr_mem_we", mem_we, 1);
    tick();
    // Beat 2: read back.
    beat(1'b0, 16'h0020, 8'h00);
    #1;
    check("ldr_rdata", bus.ldr_rdata, 8'hA5);
    check("ldr_read_we", mem_we, 0);
    tick();
    cpu_we = 1'b0;
    beat(1'b1, 16'h0021, 8'h3C);
    tick();
    check("beat3_gnt", bus.ldr_gnt, 1);
    beat(1'b1, 16'h0022, 8'h77);
    #1;
    check("beat4_gnt", bus.ldr_gnt, 1);
    check("beat4_we", mem_we, 1);
    tick();

    // 3. Fourth beat reached MAX_BURST: released while req still high.
    check("burst_gnt0", bus.ldr_gnt, 0);
    check("burst_hold0", cpu_hold, 0);
    check("burst_ignored_we", mem_we, 0);
    bus.ldr_valid = 1'b0;
    tick();
    check("cool_gnt", bus.ldr_gnt, 0);
    cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    check("regrant_1st_bnd", bus.ldr_gnt, 0);
    tick();
    check("regrant_wait", bus.ldr_gnt, 0);
    cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    check("regrant_2nd_bnd", bus.ldr_gnt, 1);

    // 4. Request drops in the same cycle as beat 2.
    beat(1'b1, 16'h0040, 8'h11);
    tick();
    beat(1'b1, 16'h0041, 8'h22);
    bus.ldr_req = 1'b0;
    #1;
    check("drop_beat2_we", mem_we, 1);
    tick();
    bus.ldr_valid = 1'b0;
    check("drop_hold", cpu_hold, 0);
    check("drop_gnt", bus.ldr_gnt, 0);
    cpu_addr = 16'h0041;
    #1;
    check("drop_beat2_data", bus.ldr_rdata, 8'h22);
    cpu_addr = 16'h0022;
    #1;
    check("burst_beat4_data", bus.ldr_rdata, 8'h77);
    cpu_addr = 16'h0010;
    #1;
    check("cpu_data_kept", bus.ldr_rdata, 8'h5A);

    // COOL -> CPU; WAIT abandoned when req drops; boundary ignored in S_CPU.
    cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    bus.ldr_req = 1'b1;
    tick();
    bus.ldr_req = 1'b0;
    tick();
    cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    check("cpu_ignores_bnd", bus.ldr_gnt, 0);

    // 5. Asynchronous reset during beat 3.
    bus.ldr_req = 1'b1;
    tick();
    cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    check("rst_case_gnt", bus.ldr_gnt, 1);
    beat(1'b1, 16'h0050, 8'h01);
    tick();
    beat(1'b1, 16'h0051, 8'h02);
    tick();
    beat(1'b1, 16'h0052, 8'h03);
    #2;
    rst = 1'b0;
    #1;
    check("async_gnt", bus.ldr_gnt, 0);
    check("async_hold", cpu_hold, 0);
    check("async_mem_we", mem_we, 0);
    bus.ldr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_wait", bus.ldr_gnt, 0);
    cpu_boundary = 1'b1;
    tick();
    cpu_boundary = 1'b0;
    check("post_rst_grant", bus.ldr_gnt, 1);

`ifdef ARB_TIMEOUT_EN
    // 6. Idle grant revoked after TIMEOUT=8 idle cycles; ldr_timeout pulses once.
    for (int i = 0; i < 7; i++) tick();
    check("to_gnt_still", bus.ldr_gnt, 1);
    check("to_no_pulse", bus.ldr_timeout, 0);
    tick();
    check("to_revoked", bus.ldr_gnt, 0);
    check("to_pulse", bus.ldr_timeout, 1);
    tick();
    check("to_pulse_once", bus.ldr_timeout, 0);
`else
    bus.ldr_req = 1'b0;
    tick();
    check("final_release", bus.ldr_gnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
